// File: rtl/adder_pkg.sv
// Shared definitions for the shared-adder arbiter: datapath width and FSM states.
package adder_pkg;

   localparam int WORD_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

endpackage

// File: rtl/adder_arbiter_adder.sv
// 16-bit ripple-carry adder built as four chained 4-bit ripple nibbles.
module adder
   import adder_pkg::*;
(
   input  logic [WORD_W-1:0] x,
   input  logic [WORD_W-1:0] y,
   input  logic              cin,
   output logic [WORD_W-1:0] sum,
   output logic              cout
);

   localparam int NIB = WORD_W / 4;

   logic [WORD_W:0] carry;

   assign carry[0] = cin;

   // Each nibble ripples its carry into the next; bit b is a plain full adder.
   for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      for (genvar gj = 0; gj < 4; gj++) begin : g_bit
         localparam int B = 4 * gi + gj;
         assign sum[B]     = x[B] ^ y[B] ^ carry[B];
         assign carry[B+1] = (x[B] & y[B]) | (carry[B] & (x[B] ^ y[B]));
      end
   end

   assign cout = carry[WORD_W];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one 16-bit adder between NREQ requesters,
// with a registered result held under valid/ready backpressure.
module adder_arbiter
   import adder_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WORD_W-1:0] opx,
   input  logic [NREQ*WORD_W-1:0] opy,
   input  logic [NREQ-1:0]        cin,
   output logic [NREQ-1:0]        gnt,
   output logic                   res_valid,
   output logic [IDW-1:0]         res_id,
   output logic [WORD_W-1:0]      res_sum,
   output logic                   res_cout,
   input  logic                   res_ready,
   output logic                   busy,
   output logic [15:0]            ops_done
);

   state_t              state_reg,     state_next;
   logic [IDW-1:0]      ptr_reg,       ptr_next;
   logic [WORD_W-1:0]   opx_reg,       opx_next;
   logic [WORD_W-1:0]   opy_reg,       opy_next;
   logic                cin_reg,       cin_next;
   logic [NREQ-1:0]     gnt_reg,       gnt_next;
   logic                res_valid_reg, res_valid_next;
   logic [IDW-1:0]      res_id_reg,    res_id_next;
   logic [WORD_W-1:0]   res_sum_reg,   res_sum_next;
   logic                res_cout_reg,  res_cout_next;
   logic [15:0]         ops_done_reg,  ops_done_next;

   logic                sel_found;
   logic [IDW-1:0]      sel_idx;
   logic [IDW:0]        cand;
   logic [WORD_W-1:0]   add_sum;
   logic                add_cout;

   adder u_adder (
      .x    (opx_reg),
      .y    (opy_reg),
      .cin  (cin_reg),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Round-robin pick: scan from ptr upward (wrapping); scanning in reverse
   // lets the candidate closest to ptr overwrite the others.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_reg} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (req[cand[IDW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IDW-1:0];
         end
      end
   end

   // Next-state and datapath register updates for IDLE -> CALC -> HOLD.
   always_comb begin
      state_next     = state_reg;
      ptr_next       = ptr_reg;
      opx_next       = opx_reg;
      opy_next       = opy_reg;
      cin_next       = cin_reg;
      gnt_next       = '0;
      res_valid_next = res_valid_reg;
      res_id_next    = res_id_reg;
      res_sum_next   = res_sum_reg;
      res_cout_next  = res_cout_reg;
      ops_done_next  = ops_done_reg;
      case (state_reg)
         ST_IDLE: begin
            if (sel_found) begin
               opx_next          = opx[sel_idx*WORD_W +: WORD_W];
               opy_next          = opy[sel_idx*WORD_W +: WORD_W];
               cin_next          = cin[sel_idx];
               res_id_next       = sel_idx;
               gnt_next[sel_idx] = 1'b1;
               state_next        = ST_CALC;
            end
         end
         ST_CALC: begin
            res_sum_next   = add_sum;
            res_cout_next  = add_cout;
            res_valid_next = 1'b1;
            state_next     = ST_HOLD;
         end
         ST_HOLD: begin
            if (res_ready) begin
               res_valid_next = 1'b0;
               ops_done_next  = ops_done_reg + 16'd1;
               // Winner drops to lowest priority for the next round.
               if (res_id_reg == IDW'(NREQ - 1)) begin
                  ptr_next = '0;
               end else begin
                  ptr_next = res_id_reg + 1'b1;
               end
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // State and result registers; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_IDLE;
         ptr_reg       <= '0;
         opx_reg       <= '0;
         opy_reg       <= '0;
         cin_reg       <= 1'b0;
         gnt_reg       <= '0;
         res_valid_reg <= 1'b0;
         res_id_reg    <= '0;
         res_sum_reg   <= '0;
         res_cout_reg  <= 1'b0;
         ops_done_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         ptr_reg       <= ptr_next;
         opx_reg       <= opx_next;
         opy_reg       <= opy_next;
         cin_reg       <= cin_next;
         gnt_reg       <= gnt_next;
         res_valid_reg <= res_valid_next;
         res_id_reg    <= res_id_next;
         res_sum_reg   <= res_sum_next;
         res_cout_reg  <= res_cout_next;
         ops_done_reg  <= ops_done_next;
      end
   end

   assign gnt       = gnt_reg;
   assign res_valid = res_valid_reg;
   assign res_id    = res_id_reg;
   assign res_sum   = res_sum_reg;
   assign res_cout  = res_cout_reg;
   assign busy      = (state_reg != ST_IDLE);
   assign ops_done  = ops_done_reg;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: directed operations push expected
// results; a forked monitor pops and compares on every accepted result.
module tb_adder_arbiter;

   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req;
   logic [NREQ*16-1:0] opx;
   logic [NREQ*16-1:0] opy;
   logic [NREQ-1:0]   cin;
   logic [NREQ-1:0]   gnt;
   logic              res_valid;
   logic [IDW-1:0]    res_id;
   logic [15:0]       res_sum;
   logic              res_cout;
   logic              res_ready;
   logic              busy;
   logic [15:0]       ops_done;

   typedef struct packed {
      logic [1:0]  id;
      logic [15:0] sum;
      logic        cout;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .opx       (opx),
      .opy       (opy),
      .cin       (cin),
      .gnt       (gnt),
      .res_valid (res_valid),
      .res_id    (res_id),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_ready (res_ready),
      .busy      (busy),
      .ops_done  (ops_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
      n_checks++;
      if (act !== req_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, req_v);
      end
   endtask

   task automatic set_ops(input int i, input logic [15:0] x, input logic [15:0] y, input logic c);
      opx[16*i +: 16] = x;
      opy[16*i +: 16] = y;
      cin[i]          = c;
   endtask

   task automatic push_exp(input int i, input logic [15:0] s, input logic c);
      exp_t e;
      e.id   = 2'(i);
      e.sum  = s;
      e.cout = c;
      sb.push_back(e);
   endtask

   // Waits for the next grant and checks both who got it and how many cycles it took.
   task automatic wait_gnt(input int i, input int lat);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (gnt == '0 && t < 20);
      check("gnt_onehot", {28'b0, gnt}, 32'(1) << i);
      check("gnt_latency", t, lat);
   endtask

   task automatic wait_idle();
      int t = 0;
      while (busy && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("idle_timeout", {31'b0, busy}, 32'd0);
   endtask

   task automatic do_op(input int i, input logic [15:0] x, input logic [15:0] y,
                        input logic c, input logic [15:0] es, input logic ec);
      push_exp(i, es, ec);
      set_ops(i, x, y, c);
      req[i] = 1'b1;
      wait_gnt(i, 1);
      req[i] = 1'b0;
      @(negedge clk);
      check("res_valid_latency", {31'b0, res_valid}, 32'd1);
      wait_idle();
   endtask

   logic [15:0] cont_sum[5] = '{16'h0111, 16'h0222, 16'h0333, 16'h0444, 16'h0111};
   int          cont_id[5]  = '{0, 1, 2, 3, 0};

   initial begin
      rst       = 1'b1;
      req       = '0;
      opx       = '0;
      opy       = '0;
      cin       = '0;
      res_ready = 1'b1;

      // Monitor: sample mid-low-phase, after the driver has settled its inputs.
      fork
         forever begin
            @(negedge clk);
            #2;
            if (!rst && res_valid && res_ready) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: got id=%0d sum=%h cout=%b expected none",
                           res_id, res_sum, res_cout);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  $display("result id=%0d sum=%h cout=%b (expected id=%0d sum=%h cout=%b)",
                           res_id, res_sum, res_cout, e.id, e.sum, e.cout);
                  check("result", {13'b0, res_id, res_sum, res_cout}, {13'b0, e});
               end
            end
         end
      join_none

      repeat (3) @(negedge clk);
      check("rst_gnt",       {28'b0, gnt},       32'd0);
      check("rst_res_valid", {31'b0, res_valid}, 32'd0);
      check("rst_busy",      {31'b0, busy},      32'd0);
      check("rst_ops_done",  {16'b0, ops_done},  32'd0);
      check("rst_res_sum",   {16'b0, res_sum},   32'd0);
      check("rst_res_id",    {30'b0, res_id},    32'd0);
      check("rst_res_cout",  {31'b0, res_cout},  32'd0);
      rst = 1'b0;

      // Single operation and carry-out boundaries.
      do_op(2, 16'h1234, 16'h0FF0, 1'b0, 16'h2224, 1'b0);
      check("ops_done_1", {16'b0, ops_done}, 32'd1);
      do_op(0, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1);
      do_op(0, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
      check("ops_done_3", {16'b0, ops_done}, 32'd3);

      // Counter wrap: preload the counter to its top value, then accept one op.
      force dut.ops_done_reg = 16'hFFFF;
      @(negedge clk);
      release dut.ops_done_reg;
      do_op(1, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
      check("ops_done_wrap", {16'b0, ops_done}, 32'd0);
      do_op(3, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0);
      check("ops_done_after_wrap", {16'b0, ops_done}, 32'd1);

      // Contention: every requester held high out of reset.
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         set_ops(i, 16'h0100 * 16'(i + 1), 16'h0011 * 16'(i + 1), 1'b0);
      end
      req = 4'hF;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 5; k++) push_exp(cont_id[k], cont_sum[k], 1'b0);
      rst = 1'b0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (k % 3 == 0) check("cont_gnt", {28'b0, gnt}, 32'(1) << cont_id[k/3]);
         else            check("cont_gnt_idle", {28'b0, gnt}, 32'd0);
      end
      req = '0;
      check("ops_done_5", {16'b0, ops_done}, 32'd5);

      // Backpressure: hold the result for 10 cycles while others request.
      res_ready = 1'b0;
      push_exp(1, 16'h0009, 1'b0);
      set_ops(1, 16'h0005, 16'h0003, 1'b1);
      req = 4'b0010;
      wait_gnt(1, 1);
      set_ops(0, 16'h1000, 16'h0234, 1'b0);
      set_ops(2, 16'h00A0, 16'h000A, 1'b0);
      set_ops(3, 16'hF000, 16'h2000, 1'b0);
      req = 4'b1101;
      @(negedge clk);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_valid", {31'b0, res_valid}, 32'd1);
         check("bp_sum",   {16'b0, res_sum},   32'h0009);
         check("bp_id",    {30'b0, res_id},    32'd1);
         check("bp_no_gnt", {28'b0, gnt},     32'd0);
      end
      res_ready = 1'b1;
      @(negedge clk);
      check("bp_release_valid", {31'b0, res_valid}, 32'd0);
      @(negedge clk);
      check("bp_next_gnt", {28'b0, gnt}, 32'b0100);
      req[2]    = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      check("hold_sum_aa", {16'b0, res_sum}, 32'h00AA);
      check("hold_busy",   {31'b0, busy},    32'd1);
      check("ops_done_6",  {16'b0, ops_done}, 32'd6);

      // Reset in HOLD: result discarded, pointer back to 0.
      rst = 1'b1;
      @(negedge clk);
      check("midrst_valid",    {31'b0, res_valid}, 32'd0);
      check("midrst_busy",     {31'b0, busy},      32'd0);
      check("midrst_ops_done", {16'b0, ops_done},  32'd0);
      check("midrst_gnt",      {28'b0, gnt},       32'd0);
      rst       = 1'b0;
      res_ready = 1'b1;
      push_exp(0, 16'h1234, 1'b0);
      push_exp(3, 16'h1000, 1'b1);
      wait_gnt(0, 1);
      req[0] = 1'b0;
      wait_gnt(3, 3);
      req[3] = 1'b0;
      @(negedge clk);
      wait_idle();
      check("ops_done_2", {16'b0, ops_done}, 32'd2);
      check("sb_empty", sb.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
